wb_stage: RTL and testbench
===========================

# wb_stage

Parametrised write-back stage for the veriRISCV core, replacing the pass-through WB. It registers the MEM/WB result and selects the write-back source (ALU, load, CSR, PC+4). It aligns and sign/zero-extends load data and stalls the pipeline while a load response is outstanding. It sits between the MEM stage and the register file, and drives the register-file write port and retire/illegal-instruction events.

## Interface
- XLEN, default 32, datapath width (32 or 64)
- RF_AW, default 5, register-file address width
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- mem_valid  input  1  MEM/WB entry holds an instruction
- mem_reg_wen  input  1  instruction writes rd
- mem_reg_waddr  input  RF_AW  rd index
- mem_alu_out  input  XLEN  ALU result / load address
- mem_csr_rdata  input  XLEN  CSR read value
- mem_pc  input  XLEN  instruction PC
- mem_wb_sel  input  2  source: 0 ALU, 1 LOAD, 2 CSR, 3 PC+4
- mem_load_size  input  2  0 byte, 1 half, 2 word, 3 double (XLEN=64 only)
- mem_load_unsigned  input  1  zero-extend load
- mem_ill_instr  input  1  illegal instruction flag
- dmem_rvalid  input  1  load data valid this cycle
- dmem_rdata  input  XLEN  load data (full aligned word)
- wb_stall  output  1  WB cannot accept; upstream freezes
- wb_reg_wen  output  1  register-file write enable (registered)
- wb_reg_waddr  output  RF_AW  write address (registered)
- wb_reg_wdata  output  XLEN  write data (registered)
- wb_retire  output  1  one-cycle pulse per completed instruction
- wb_ill_instr  output  1  one-cycle pulse for completed illegal instruction

## Operation
- FSM with two states, IDLE and WAIT_LOAD.
- IDLE, mem_valid=1:
  - Non-load: commit on the next edge.
  - Load with dmem_rvalid=1: commit on the next edge.
  - Load with dmem_rvalid=0: latch rd, wen, size, unsigned and alu_out[2:0], then go to WAIT_LOAD.
- WAIT_LOAD:
  - MEM inputs are ignored, because upstream holds the same entry.
  - On dmem_rvalid=1, commit the latched load on the next edge and return to IDLE.
- dmem_rvalid with no load pending is ignored.
- wb_stall is combinational:
  - IDLE, mem_valid=1, wb_sel=LOAD and dmem_rvalid=0: stall=1.
  - WAIT_LOAD and dmem_rvalid=0: stall=1.
  - Otherwise stall=0.
- Source data:
  - ALU gives alu_out.
  - CSR gives csr_rdata.
  - PC+4 gives mem_pc+4, modulo 2^XLEN.
  - LOAD gives aligned data.
- Load alignment:
  - Lane is selected by the address low bits: byte uses addr[log2(XLEN/8)-1:0], half uses addr[..:1], word (XLEN=64) uses addr[2].
  - Result is sign-extended, or zero-extended when unsigned=1.
  - Size 3 with XLEN=32 is treated as word.
- Misalignment is not checked here; MEM traps it before WB.
- Commit:
  - wb_reg_wen is mem_reg_wen AND rd≠0 AND NOT ill_instr.
  - wb_retire=1.
  - wb_ill_instr equals ill_instr.
  - wb_reg_waddr and wb_reg_wdata update even when wen=0.
- No commit in a cycle: wb_reg_wen=0, wb_retire=0, wb_ill_instr=0, and waddr/wdata hold their values.

## Timing
- Reset: state IDLE; wb_reg_wen, wb_retire and wb_ill_instr are 0; wb_reg_waddr and wb_reg_wdata are 0. Any latched load is discarded with no write.
- Latency: one cycle from accept (or from dmem_rvalid in WAIT_LOAD) to wb_reg_wen.
- Back-to-back non-loads commit every cycle.
- A load with a response N cycles late:
  - Stall lasts N cycles.
  - Commit is N+1 cycles after it is first presented.
- wb_stall falls in the same cycle dmem_rvalid rises. Upstream advances on that edge, so the held entry is never accepted twice.
- rst has priority over every other event.

## Structure
- Shared package (core.vh) holds:
  - WB_SEL_ALU/LOAD/CSR/PC4 encodings.
  - LOAD_SIZE_B/H/W/D encodings.
  - FSM state encodings.
- Sub-module wb_load_align is purely combinational: dmem_rdata, offset, size and unsigned in; XLEN result out. It is unit-testable alone.
- The stage holds the FSM, the latch registers, the source mux and the output registers.

## Test plan
- ALU op: rd=5, alu_out=0x1234 → next cycle wb_reg_wen=1, waddr=5, wdata=0x1234, wb_retire=1.
- rd=0, wen=1 → wb_reg_wen=0, wb_retire=1; wb_sel=PC4 with pc=0xFFFFFFFC → wdata=0x0.
- LB, addr low bits=1, rdata=0x00008000 (byte 0x80), rvalid same cycle → wdata=0xFFFFFF80; LBU → 0x00000080.
- LHU at offset 2, rvalid 3 cycles late, rdata=0xBEEF0000 → wb_stall=1 for 3 cycles, wdata=0x0000BEEF one cycle after rvalid, exactly one commit.
- Illegal instr with wen=1 → wb_reg_wen=0, wb_ill_instr=1 for one cycle; a spurious rvalid while IDLE with no load → no effect.
- rst asserted in WAIT_LOAD → state IDLE, stall=0, no write; XLEN=64: LW at addr[2]=1, rdata=0x80000000_00000000 → wdata=0xFFFFFFFF_80000000.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: source select, load size and FSM state.
package wb_stage_pkg;

   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_LOAD = 2'd1;
   localparam logic [1:0] WB_SEL_CSR  = 2'd2;
   localparam logic [1:0] WB_SEL_PC4  = 2'd3;

   localparam logic [1:0] LOAD_SIZE_B = 2'd0;
   localparam logic [1:0] LOAD_SIZE_H = 2'd1;
   localparam logic [1:0] LOAD_SIZE_W = 2'd2;
   localparam logic [1:0] LOAD_SIZE_D = 2'd3;

   typedef enum logic {
      StIdle,
      StWaitLoad
   } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB handshake bundle: master is the upstream/memory side, slave is the WB stage.
interface wb_stage_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RF_AW = 5
);
   logic             mem_valid;
   logic             mem_reg_wen;
   logic [RF_AW-1:0] mem_reg_waddr;
   logic [XLEN-1:0]  mem_alu_out;
   logic [XLEN-1:0]  mem_csr_rdata;
   logic [XLEN-1:0]  mem_pc;
   logic [1:0]       mem_wb_sel;
   logic [1:0]       mem_load_size;
   logic             mem_load_unsigned;
   logic             mem_ill_instr;
   logic             dmem_rvalid;
   logic [XLEN-1:0]  dmem_rdata;
   logic             wb_stall;
   logic             wb_reg_wen;
   logic [RF_AW-1:0] wb_reg_waddr;
   logic [XLEN-1:0]  wb_reg_wdata;
   logic             wb_retire;
   logic             wb_ill_instr;

   modport master (
      output mem_valid, mem_reg_wen, mem_reg_waddr, mem_alu_out, mem_csr_rdata, mem_pc,
             mem_wb_sel, mem_load_size, mem_load_unsigned, mem_ill_instr, dmem_rvalid,
             dmem_rdata,
      input  wb_stall, wb_reg_wen, wb_reg_waddr, wb_reg_wdata, wb_retire, wb_ill_instr
   );

   modport slave (
      input  mem_valid, mem_reg_wen, mem_reg_waddr, mem_alu_out, mem_csr_rdata, mem_pc,
             mem_wb_sel, mem_load_size, mem_load_unsigned, mem_ill_instr, dmem_rvalid,
             dmem_rdata,
      output wb_stall, wb_reg_wen, wb_reg_waddr, wb_reg_wdata, wb_retire, wb_ill_instr
   );

endinterface

// File: rtl/wb_load_align.sv
// Combinational load lane extraction with sign/zero extension.
module wb_load_align
   import wb_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rdata_i,
   input  logic [2:0]      offset_i,
   input  logic [1:0]      size_i,
   input  logic            unsigned_i,
   output logic [XLEN-1:0] result_o
);

   logic [2:0]      byte_off;
   logic [5:0]      shamt;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] keep_mask;
   logic            sign_bit;

   always_comb begin
      byte_off  = offset_i;
      keep_mask = '1;
      sign_bit  = 1'b0;
      // Offsets are rounded down to the access size; MEM has already trapped misalignment.
      unique case (size_i)
         LOAD_SIZE_B: ;
         LOAD_SIZE_H: byte_off[0]   = 1'b0;
         LOAD_SIZE_W: byte_off[1:0] = 2'b00;
         LOAD_SIZE_D: byte_off      = 3'b000;
      endcase
      if (XLEN == 32) byte_off[2] = 1'b0;
      shamt   = {byte_off, 3'b000};
      shifted = rdata_i >> shamt;

      unique case (size_i)
         LOAD_SIZE_B: begin
            keep_mask = XLEN'(8'hFF);
            sign_bit  = shifted[7];
         end
         LOAD_SIZE_H: begin
            keep_mask = XLEN'(16'hFFFF);
            sign_bit  = shifted[15];
         end
         LOAD_SIZE_W: begin
            keep_mask = XLEN'(32'hFFFF_FFFF);
            sign_bit  = shifted[31];
         end
         LOAD_SIZE_D: begin
            // A double on a 32-bit core degrades to a word, which fills the whole datapath.
            keep_mask = '1;
            sign_bit  = shifted[XLEN-1];
         end
      endcase

      result_o = shifted & keep_mask;
      if (!unsigned_i && sign_bit) result_o = result_o | ~keep_mask;
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: source select, load alignment, load-wait FSM and registered RF write port.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RF_AW = 5
) (
   input logic        clk,
   input logic        rst,
   wb_stage_if.slave  bus
);

   wb_state_e state_q, state_d;

   logic [RF_AW-1:0] ld_waddr_q, ld_waddr_d;
   logic             ld_wen_q, ld_wen_d;
   logic             ld_ill_q, ld_ill_d;
   logic             ld_uns_q, ld_uns_d;
   logic [1:0]       ld_size_q, ld_size_d;
   logic [2:0]       ld_off_q, ld_off_d;

   logic             wb_wen_q, wb_wen_d;
   logic             wb_retire_q, wb_retire_d;
   logic             wb_ill_q, wb_ill_d;
   logic [RF_AW-1:0] wb_waddr_q, wb_waddr_d;
   logic [XLEN-1:0]  wb_wdata_q, wb_wdata_d;

   logic [2:0]       al_off;
   logic [1:0]       al_size;
   logic             al_uns;
   logic [XLEN-1:0]  al_result;
   logic [XLEN-1:0]  src_data;

   logic             stall;
   logic             commit;
   logic             c_wen;
   logic             c_ill;
   logic [RF_AW-1:0] c_waddr;
   logic [XLEN-1:0]  c_wdata;

   // While waiting, the aligner works from the latched request, not the held MEM entry.
   always_comb begin
      al_off  = bus.mem_alu_out[2:0];
      al_size = bus.mem_load_size;
      al_uns  = bus.mem_load_unsigned;
      if (state_q == StWaitLoad) begin
         al_off  = ld_off_q;
         al_size = ld_size_q;
         al_uns  = ld_uns_q;
      end
   end

   wb_load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .rdata_i    (bus.dmem_rdata),
      .offset_i   (al_off),
      .size_i     (al_size),
      .unsigned_i (al_uns),
      .result_o   (al_result)
   );

   always_comb begin
      src_data = bus.mem_alu_out;
      unique case (bus.mem_wb_sel)
         WB_SEL_ALU:  src_data = bus.mem_alu_out;
         WB_SEL_LOAD: src_data = al_result;
         WB_SEL_CSR:  src_data = bus.mem_csr_rdata;
         WB_SEL_PC4:  src_data = bus.mem_pc + XLEN'(4);
      endcase
   end

   always_comb begin
      state_d    = state_q;
      ld_waddr_d = ld_waddr_q;
      ld_wen_d   = ld_wen_q;
      ld_ill_d   = ld_ill_q;
      ld_uns_d   = ld_uns_q;
      ld_size_d  = ld_size_q;
      ld_off_d   = ld_off_q;
      stall      = 1'b0;
      commit     = 1'b0;
      c_wen      = bus.mem_reg_wen;
      c_ill      = bus.mem_ill_instr;
      c_waddr    = bus.mem_reg_waddr;
      c_wdata    = src_data;
      unique case (state_q)
         StIdle: begin
            if (bus.mem_valid) begin
               if (bus.mem_wb_sel == WB_SEL_LOAD && !bus.dmem_rvalid) begin
                  stall      = 1'b1;
                  state_d    = StWaitLoad;
                  ld_waddr_d = bus.mem_reg_waddr;
                  ld_wen_d   = bus.mem_reg_wen;
                  ld_ill_d   = bus.mem_ill_instr;
                  ld_uns_d   = bus.mem_load_unsigned;
                  ld_size_d  = bus.mem_load_size;
                  ld_off_d   = bus.mem_alu_out[2:0];
               end else begin
                  commit = 1'b1;
               end
            end
         end
         StWaitLoad: begin
            c_wen   = ld_wen_q;
            c_ill   = ld_ill_q;
            c_waddr = ld_waddr_q;
            c_wdata = al_result;
            if (bus.dmem_rvalid) begin
               commit  = 1'b1;
               state_d = StIdle;
            end else begin
               stall = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      wb_wen_d    = commit & c_wen & (c_waddr != '0) & ~c_ill;
      wb_retire_d = commit;
      wb_ill_d    = commit & c_ill;
      wb_waddr_d  = commit ? c_waddr : wb_waddr_q;
      wb_wdata_d  = commit ? c_wdata : wb_wdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         ld_waddr_q  <= '0;
         ld_wen_q    <= 1'b0;
         ld_ill_q    <= 1'b0;
         ld_uns_q    <= 1'b0;
         ld_size_q   <= '0;
         ld_off_q    <= '0;
         wb_wen_q    <= 1'b0;
         wb_retire_q <= 1'b0;
         wb_ill_q    <= 1'b0;
         wb_waddr_q  <= '0;
         wb_wdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         ld_waddr_q  <= ld_waddr_d;
         ld_wen_q    <= ld_wen_d;
         ld_ill_q    <= ld_ill_d;
         ld_uns_q    <= ld_uns_d;
         ld_size_q   <= ld_size_d;
         ld_off_q    <= ld_off_d;
         wb_wen_q    <= wb_wen_d;
         wb_retire_q <= wb_retire_d;
         wb_ill_q    <= wb_ill_d;
         wb_waddr_q  <= wb_waddr_d;
         wb_wdata_q  <= wb_wdata_d;
      end
   end

   assign bus.wb_stall     = stall;
   assign bus.wb_reg_wen   = wb_wen_q;
   assign bus.wb_retire    = wb_retire_q;
   assign bus.wb_ill_instr = wb_ill_q;
   assign bus.wb_reg_waddr = wb_waddr_q;
   assign bus.wb_reg_wdata = wb_wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage: 32- and 64-bit instances checked against an arithmetic model.
module tb_wb_stage;
   import wb_stage_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_stage_if #(.XLEN(32), .RF_AW(5)) bus32 ();
   wb_stage_if #(.XLEN(64), .RF_AW(5)) bus64 ();

   wb_stage #(.XLEN(32), .RF_AW(5)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
   wb_stage #(.XLEN(64), .RF_AW(5)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

   logic        sel64 = 1'b0;
   logic        t_valid = 1'b0, t_wen = 1'b0, t_uns = 1'b0, t_ill = 1'b0, t_rvalid = 1'b0;
   logic [1:0]  t_sel = 2'd0, t_size = 2'd0;
   logic [4:0]  t_rd = 5'd0;
   logic [63:0] t_alu = '0, t_csr = '0, t_pc = '0, t_rdata = '0;

   assign bus32.mem_valid         = t_valid & ~sel64;
   assign bus32.mem_reg_wen       = t_wen;
   assign bus32.mem_reg_waddr     = t_rd;
   assign bus32.mem_alu_out       = t_alu[31:0];
   assign bus32.mem_csr_rdata     = t_csr[31:0];
   assign bus32.mem_pc            = t_pc[31:0];
   assign bus32.mem_wb_sel        = t_sel;
   assign bus32.mem_load_size     = t_size;
   assign bus32.mem_load_unsigned = t_uns;
   assign bus32.mem_ill_instr     = t_ill;
   assign bus32.dmem_rvalid       = t_rvalid & ~sel64;
   assign bus32.dmem_rdata        = t_rdata[31:0];

   assign bus64.mem_valid         = t_valid & sel64;
   assign bus64.mem_reg_wen       = t_wen;
   assign bus64.mem_reg_waddr     = t_rd;
   assign bus64.mem_alu_out       = t_alu;
   assign bus64.mem_csr_rdata     = t_csr;
   assign bus64.mem_pc            = t_pc;
   assign bus64.mem_wb_sel        = t_sel;
   assign bus64.mem_load_size     = t_size;
   assign bus64.mem_load_unsigned = t_uns;
   assign bus64.mem_ill_instr     = t_ill;
   assign bus64.dmem_rvalid       = t_rvalid & sel64;
   assign bus64.dmem_rdata        = t_rdata;

   logic        o_stall, o_wen, o_retire, o_ill;
   logic [4:0]  o_waddr;
   logic [63:0] o_wdata;
   assign o_stall  = sel64 ? bus64.wb_stall     : bus32.wb_stall;
   assign o_wen    = sel64 ? bus64.wb_reg_wen   : bus32.wb_reg_wen;
   assign o_retire = sel64 ? bus64.wb_retire    : bus32.wb_retire;
   assign o_ill    = sel64 ? bus64.wb_ill_instr : bus32.wb_ill_instr;
   assign o_waddr  = sel64 ? bus64.wb_reg_waddr : bus32.wb_reg_waddr;
   assign o_wdata  = sel64 ? bus64.wb_reg_wdata : {32'b0, bus32.wb_reg_wdata};

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [4:0]  exp_waddr = '0;
   logic [63:0] exp_wdata = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: pick the naturally aligned lane, then extend, using plain arithmetic.
   function automatic logic [63:0] model_load(input int xlen, input logic [63:0] rdata,
                                              input logic [2:0] addr, input logic [1:0] size,
                                              input bit uns);
      int nb, off;
      logic [63:0] v, m;
      nb  = (size == 2'd3 && xlen == 32) ? 4 : (1 << size);
      off = int'(addr) % (xlen / 8);
      off = off - (off % nb);
      v   = rdata >> (8 * off);
      if (nb < 8) begin
         m = (64'h1 << (8 * nb)) - 64'h1;
         v = v & m;
         if (!uns && v[8*nb-1]) v = v | ~m;
      end
      if (xlen == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   function automatic logic [63:0] model_wdata(input int xlen, input logic [1:0] sel,
                                               input logic [63:0] alu, input logic [63:0] csr,
                                               input logic [63:0] pc, input logic [63:0] rdata,
                                               input logic [1:0] size, input bit uns);
      logic [63:0] mask;
      mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
      case (sel)
         2'd0:    return alu & mask;
         2'd1:    return model_load(xlen, rdata, alu[2:0], size, uns);
         2'd2:    return csr & mask;
         default: return (pc + 64'd4) & mask;
      endcase
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_retire"}, {63'b0, o_retire}, 64'd0);
      check({tag, "_wen"}, {63'b0, o_wen}, 64'd0);
      check({tag, "_ill"}, {63'b0, o_ill}, 64'd0);
      check({tag, "_waddr"}, {59'b0, o_waddr}, {59'b0, exp_waddr});
      check({tag, "_wdata"}, o_wdata, exp_wdata);
   endtask

   // Presents one MEM/WB entry (or a bubble) and holds it for lat cycles if it is a load.
   task automatic present(input bit valid, input logic [1:0] sel, input logic [4:0] rd,
                          input bit wen, input bit ill, input bit uns, input logic [1:0] size,
                          input logic [63:0] alu, input logic [63:0] csr, input logic [63:0] pc,
                          input logic [63:0] rdata, input int lat);
      int          xlen;
      bit          is_load;
      logic [63:0] exp_d;
      xlen    = sel64 ? 64 : 32;
      is_load = valid && (sel == WB_SEL_LOAD);
      if (is_load) begin
         for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            t_valid = valid; t_sel = sel; t_rd = rd; t_wen = wen; t_ill = ill; t_uns = uns;
            t_size = size; t_alu = alu; t_csr = csr; t_pc = pc;
            t_rdata = {$urandom, $urandom}; t_rvalid = 1'b0;
            #1 check("stall_wait", {63'b0, o_stall}, 64'd1);
            @(posedge clk);
            #1 check_quiet("wait");
         end
      end
      @(negedge clk);
      t_valid = valid; t_sel = sel; t_rd = rd; t_wen = wen; t_ill = ill; t_uns = uns;
      t_size = size; t_alu = alu; t_csr = csr; t_pc = pc; t_rdata = rdata;
      t_rvalid = is_load ? 1'b1 : 1'($urandom_range(0, 1));
      #1 check("stall_go", {63'b0, o_stall}, 64'd0);
      @(posedge clk);
      #1;
      if (valid) begin
         exp_d     = model_wdata(xlen, sel, alu, csr, pc, rdata, size, uns);
         exp_waddr = rd;
         exp_wdata = exp_d;
         check("retire", {63'b0, o_retire}, 64'd1);
         check("wen", {63'b0, o_wen}, {63'b0, (wen && rd != 5'd0 && !ill)});
         check("ill", {63'b0, o_ill}, {63'b0, ill});
         check("waddr", {59'b0, o_waddr}, {59'b0, exp_waddr});
         check("wdata", o_wdata, exp_wdata);
      end else begin
         check_quiet("bubble");
      end
   endtask

   task automatic random_instr();
      logic [63:0] alu, csr, pc, rdata;
      int          lat;
      alu   = sel64 ? {$urandom, $urandom} : {32'b0, $urandom};
      csr   = sel64 ? {$urandom, $urandom} : {32'b0, $urandom};
      pc    = sel64 ? {$urandom, $urandom} : {32'b0, $urandom};
      rdata = sel64 ? {$urandom, $urandom} : {32'b0, $urandom};
      lat   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
      present($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), alu, csr, pc, rdata, lat);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst32_wen", {63'b0, bus32.wb_reg_wen}, 64'd0);
      check("rst32_retire", {63'b0, bus32.wb_retire}, 64'd0);
      check("rst32_ill", {63'b0, bus32.wb_ill_instr}, 64'd0);
      check("rst32_waddr", {59'b0, bus32.wb_reg_waddr}, 64'd0);
      check("rst32_wdata", {32'b0, bus32.wb_reg_wdata}, 64'd0);
      check("rst64_wdata", bus64.wb_reg_wdata, 64'd0);
      check("rst64_retire", {63'b0, bus64.wb_retire}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // ALU, rd=0 suppression, PC+4 wrap, signed/unsigned byte, late LHU, illegal, bubble.
      present(1, WB_SEL_ALU, 5'd5, 1, 0, 0, 2'd0, 64'h1234, 0, 0, 0, 0);
      present(1, WB_SEL_ALU, 5'd0, 1, 0, 0, 2'd0, 64'h55, 0, 0, 0, 0);
      present(1, WB_SEL_PC4, 5'd3, 1, 0, 0, 2'd0, 0, 0, 64'hFFFF_FFFC, 0, 0);
      present(1, WB_SEL_LOAD, 5'd4, 1, 0, 0, LOAD_SIZE_B, 64'h1001, 0, 0, 64'h8000, 0);
      present(1, WB_SEL_LOAD, 5'd4, 1, 0, 1, LOAD_SIZE_B, 64'h1001, 0, 0, 64'h8000, 0);
      present(1, WB_SEL_LOAD, 5'd6, 1, 0, 1, LOAD_SIZE_H, 64'h2002, 0, 0, 64'hBEEF_0000, 3);
      present(1, WB_SEL_CSR, 5'd8, 1, 0, 0, 2'd0, 0, 64'hCAFE_F00D, 0, 0, 0);
      present(1, WB_SEL_ALU, 5'd7, 1, 1, 0, 2'd0, 64'h99, 0, 0, 0, 0);
      present(0, WB_SEL_ALU, 5'd9, 1, 0, 0, 2'd0, 64'h77, 0, 0, 0, 0);

      // Reset while a load is outstanding discards it.
      @(negedge clk);
      t_valid = 1'b1; t_sel = WB_SEL_LOAD; t_rd = 5'd10; t_wen = 1'b1; t_ill = 1'b0;
      t_rvalid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_waddr = '0;
      exp_wdata = '0;
      check_quiet("rst_wait");
      @(negedge clk);
      rst = 1'b0; t_valid = 1'b0; t_rvalid = 1'b1;
      #1 check("rst_stall", {63'b0, o_stall}, 64'd0);
      @(posedge clk);
      #1 check_quiet("rst_late_rvalid");

      for (int i = 0; i < 200; i++) random_instr();

      // 64-bit instance: LW from the upper word, LD, then random traffic.
      @(negedge clk);
      t_valid = 1'b0; t_rvalid = 1'b0;
      sel64 = 1'b1;
      exp_waddr = '0;
      exp_wdata = '0;
      present(1, WB_SEL_LOAD, 5'd11, 1, 0, 0, LOAD_SIZE_W, 64'h4004, 0, 0,
              64'h8000_0000_0000_0000, 0);
      present(1, WB_SEL_LOAD, 5'd12, 1, 0, 0, LOAD_SIZE_D, 64'h4000, 0, 0,
              64'h0123_4567_89AB_CDEF, 2);
      present(1, WB_SEL_PC4, 5'd13, 1, 0, 0, 2'd0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
      for (int i = 0; i < 150; i++) random_instr();

      @(negedge clk);
      t_valid = 1'b0; t_rvalid = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
